// File: rtl/mac_rx_pkg.sv
// Shared types for the MAC receive reader: FSM encoding, frame limits and the
// output stream beat bundle.
package mac_rx_pkg;

  localparam int MAC_DATA_WIDTH    = 32;
  localparam int MAX_WORDS_DEFAULT = 380;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DISCARD,
    ST_GAP
  } rx_state_t;

  typedef struct packed {
    logic [MAC_DATA_WIDTH-1:0] data;
    logic                      first;
    logic                      last;
    logic                      error;
  } beat_t;

endpackage

// File: rtl/mac_rx_reader_if.sv
// Valid/ready word stream with frame markers, as emitted by the MAC receive reader.
interface mac_rx_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_first;
  logic                  m_last;
  logic                  m_error;

  modport master (
    output m_data, m_valid, m_first, m_last, m_error,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_first, m_last, m_error,
    output m_ready
  );
endinterface

// File: rtl/mac_rx_skid_buffer.sv
// Two-entry FIFO of stream beats with occupancy output; head entry is driven
// straight from storage so the output side is fully registered.
module mac_rx_skid_buffer
  import mac_rx_pkg::*;
(
  input  logic       data_out_clock,
  input  logic       reset,
  input  logic       push,
  input  beat_t      push_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output beat_t      out_beat,
  output logic [1:0] occupancy
);

  beat_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];
  assign occupancy = count;
  assign do_pop    = out_valid && out_ready;
  assign do_push   = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge data_out_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_rx_reader.sv
// Drains complete frames from the MAC receive pop port into a valid/ready
// stream, policing missing starts and oversize frames.
//
//   state      | meaning
//   ST_IDLE    | waiting for a complete frame in the MAC buffer
//   ST_READ    | popping and forwarding the current frame
//   ST_DISCARD | popping and dropping words up to the frame end
//   ST_GAP     | one idle cycle so the MAC can update frame_count
module mac_rx_reader
  import mac_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = MAC_DATA_WIDTH,
  parameter int COUNT_WIDTH = 7,
  parameter int MAX_WORDS   = MAX_WORDS_DEFAULT,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                   data_out_clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   data_out_start,
  input  logic                   data_out_end,
  input  logic [COUNT_WIDTH-1:0] frame_count,
  output logic                   data_out_enable,
  mac_rx_reader_if.master        m,
  output logic [STAT_WIDTH-1:0]  frames_forwarded,
  output logic [STAT_WIDTH-1:0]  frames_dropped
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic             pop_q;
  logic [1:0]       occupancy;
  logic [1:0]       credit_used;
  logic             credit_ok;
  logic             out_fire;
  logic             push;
  beat_t            push_beat;
  beat_t            head;
  logic             fwd_inc;
  logic             drop_inc;
  logic             first_word;

  // A beat leaving this cycle frees its slot, which keeps one pop per cycle
  // sustainable with the downstream always ready.
  assign out_fire    = m.m_valid && m.m_ready;
  assign credit_used = occupancy - {1'b0, out_fire} + {1'b0, pop_q};
  assign credit_ok   = (credit_used < 2'd2) && !(pop_q && data_out_end);
  assign first_word  = (word_cnt == '0);

  always_comb begin
    state_nxt       = state;
    word_cnt_nxt    = word_cnt;
    data_out_enable = 1'b0;
    push            = 1'b0;
    push_beat       = '0;
    push_beat.data  = data_out;
    push_beat.first = first_word;
    fwd_inc         = 1'b0;
    drop_inc        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_count != '0) begin
          state_nxt    = ST_READ;
          word_cnt_nxt = '0;
        end
      end
      ST_READ: begin
        data_out_enable = credit_ok;
        if (pop_q) begin
          word_cnt_nxt = word_cnt + CNT_W'(1);
          if (first_word && !data_out_start) begin
            drop_inc  = 1'b1;
            state_nxt = data_out_end ? ST_GAP : ST_DISCARD;
          end else if (!first_word && data_out_start) begin
            push            = 1'b1;
            push_beat.last  = 1'b1;
            push_beat.error = 1'b1;
            drop_inc        = 1'b1;
            state_nxt       = ST_DISCARD;
          end else if (data_out_end) begin
            push           = 1'b1;
            push_beat.last = 1'b1;
            fwd_inc        = 1'b1;
            state_nxt      = ST_GAP;
          end else if (word_cnt == CNT_W'(MAX_WORDS - 1)) begin
            push            = 1'b1;
            push_beat.last  = 1'b1;
            push_beat.error = 1'b1;
            drop_inc        = 1'b1;
            state_nxt       = ST_DISCARD;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        data_out_enable = credit_ok;
        if (pop_q && data_out_end) state_nxt = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge data_out_clock or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      pop_q            <= 1'b0;
      frames_forwarded <= '0;
      frames_dropped   <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      pop_q    <= data_out_enable;
      if (fwd_inc && (frames_forwarded != '1))
        frames_forwarded <= frames_forwarded + STAT_WIDTH'(1);
      if (drop_inc && (frames_dropped != '1))
        frames_dropped <= frames_dropped + STAT_WIDTH'(1);
    end
  end

  mac_rx_skid_buffer u_buf (
    .data_out_clock (data_out_clock),
    .reset          (reset),
    .push           (push),
    .push_beat      (push_beat),
    .out_valid      (m.m_valid),
    .out_ready      (m.m_ready),
    .out_beat       (head),
    .occupancy      (occupancy)
  );

  assign m.m_data  = head.data;
  assign m.m_first = head.first;
  assign m.m_last  = head.last;
  assign m.m_error = head.error;

endmodule
